led_status_array: RTL

Multi-channel LED status driver. It drives NUM_LEDS board LEDs, and each channel has its own run-time mode: off, on, blink, or burst. Burst means N flashes followed by a long gap. A small configuration write port sets each channel, and a global sync input phase-aligns all channels. The block sits between the control/status logic and the board LED pins, and replaces the single fixed-rate toggler.

---
 rtl/led_status_array.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/led_status_array.sv
// Multi-channel LED status driver with per-channel OFF/ON/BLINK/BURST modes,
// a configuration write port and a global phase-sync input.
module led_status_array #(
    parameter int NUM_LEDS            = 8,
    parameter int CNT_W               = 32,
    parameter int DEFAULT_HALF_PERIOD = 100_000_000,
    parameter int ACTIVE_LOW          = 0
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                cfg_wr,
    input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0]  cfg_ch,
    input  logic [1:0]                                          cfg_mode,
    input  logic [CNT_W-1:0]                                    cfg_half_period,
    input  logic [3:0]                                          cfg_burst_n,
    input  logic                                                sync,
    output logic [NUM_LEDS-1:0]                                 led
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        B_ON  = 2'd0,
        B_OFF = 2'd1,
        B_GAP = 2'd2
    } burst_state_t;

    localparam logic AL_BIT = (ACTIVE_LOW != 0);

    mode_t                 mode_q [NUM_LEDS];
    mode_t                 mode_d [NUM_LEDS];
    logic [CNT_W-1:0]      hp_q   [NUM_LEDS];
    logic [CNT_W-1:0]      hp_d   [NUM_LEDS];
    logic [3:0]            bn_q   [NUM_LEDS];
    logic [3:0]            bn_d   [NUM_LEDS];
    logic [CNT_W-1:0]      cnt_q  [NUM_LEDS];
    logic [CNT_W-1:0]      cnt_d  [NUM_LEDS];
    burst_state_t          bst_q  [NUM_LEDS];
    burst_state_t          bst_d  [NUM_LEDS];
    logic [3:0]            fidx_q [NUM_LEDS];
    logic [3:0]            fidx_d [NUM_LEDS];
    logic [1:0]            gap_q  [NUM_LEDS];
    logic [1:0]            gap_d  [NUM_LEDS];
    logic [NUM_LEDS-1:0]   lit_q;
    logic [NUM_LEDS-1:0]   lit_d;
    logic [NUM_LEDS-1:0]   led_q;
    logic [NUM_LEDS-1:0]   led_d;

    // A half-period of 0 behaves as 1, so the channel ticks every cycle.
    function automatic logic is_tick(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] hp);
        logic [CNT_W-1:0] term_v;
        if (hp == {CNT_W{1'b0}}) begin
            term_v = {CNT_W{1'b0}};
        end else begin
            term_v = hp - CNT_W'(1);
        end
        return cnt == term_v;
    endfunction

    // A burst count of 0 behaves as a single flash per frame.
    function automatic logic is_last_flash(input logic [3:0] fidx, input logic [3:0] bn);
        logic [3:0] bn_eff_v;
        if (bn == 4'd0) begin
            bn_eff_v = 4'd1;
        end else begin
            bn_eff_v = bn;
        end
        return fidx == (bn_eff_v - 4'd1);
    endfunction

    // Per-channel next state: configuration load, phase restart and mode sequencing.
    always_comb begin
        mode_d = mode_q;
        hp_d   = hp_q;
        bn_d   = bn_q;
        cnt_d  = cnt_q;
        bst_d  = bst_q;
        fidx_d = fidx_q;
        gap_d  = gap_q;
        lit_d  = lit_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (cfg_wr && (int'(cfg_ch) == i)) begin
                mode_d[i] = mode_t'(cfg_mode);
                hp_d[i]   = cfg_half_period;
                bn_d[i]   = cfg_burst_n;
            end else begin
                mode_d[i] = mode_q[i];
            end
            // A restart uses the (possibly just written) mode to pick the start level.
            if ((cfg_wr && (int'(cfg_ch) == i)) || sync) begin
                cnt_d[i]  = {CNT_W{1'b0}};
                fidx_d[i] = 4'd0;
                gap_d[i]  = 2'd0;
                bst_d[i]  = B_ON;
                lit_d[i]  = (mode_d[i] != MODE_OFF);
            end else begin
                case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i] = {CNT_W{1'b0}};
                        lit_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d[i] = {CNT_W{1'b0}};
                        lit_d[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (is_tick(cnt_q[i], hp_q[i])) begin
                            cnt_d[i] = {CNT_W{1'b0}};
                            lit_d[i] = ~lit_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_BURST: begin
                        if (is_tick(cnt_q[i], hp_q[i])) begin
                            cnt_d[i] = {CNT_W{1'b0}};
                            case (bst_q[i])
                                B_ON: begin
                                    lit_d[i] = 1'b0;
                                    if (is_last_flash(fidx_q[i], bn_q[i])) begin
                                        bst_d[i] = B_GAP;
                                    end else begin
                                        bst_d[i] = B_OFF;
                                    end
                                end
                                B_OFF: begin
                                    fidx_d[i] = fidx_q[i] + 4'd1;
                                    bst_d[i]  = B_ON;
                                    lit_d[i]  = 1'b1;
                                end
                                B_GAP: begin
                                    if (gap_q[i] == 2'd3) begin
                                        gap_d[i]  = 2'd0;
                                        fidx_d[i] = 4'd0;
                                        bst_d[i]  = B_ON;
                                        lit_d[i]  = 1'b1;
                                    end else begin
                                        gap_d[i] = gap_q[i] + 2'd1;
                                        lit_d[i] = 1'b0;
                                    end
                                end
                                default: begin
                                    bst_d[i] = B_ON;
                                    lit_d[i] = 1'b1;
                                end
                            endcase
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_d[i] = {CNT_W{1'b0}};
                        lit_d[i] = 1'b0;
                    end
                endcase
            end
        end
        led_d = lit_d ^ {NUM_LEDS{AL_BIT}};
    end

    // State and output registers; reset wins over writes and sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= MODE_OFF;
                hp_q[i]   <= CNT_W'(DEFAULT_HALF_PERIOD);
                bn_q[i]   <= 4'd1;
                cnt_q[i]  <= {CNT_W{1'b0}};
                bst_q[i]  <= B_ON;
                fidx_q[i] <= 4'd0;
                gap_q[i]  <= 2'd0;
            end
            lit_q <= {NUM_LEDS{1'b0}};
            led_q <= {NUM_LEDS{AL_BIT}};
        end else begin
            mode_q <= mode_d;
            hp_q   <= hp_d;
            bn_q   <= bn_d;
            cnt_q  <= cnt_d;
            bst_q  <= bst_d;
            fidx_q <= fidx_d;
            gap_q  <= gap_d;
            lit_q  <= lit_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule
